// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit producing the update codes of the F/D, D/E
// and E/W pipeline registers and the PC enable. It resolves multi-cycle execute
// stalls, D/E read-after-write stalls, redirect flushes and the stop/halt
// sequence.
//
// Optional feature: define PIPE_CTRL_PERF_EN to build the saturating
// stall_cycles / flush_count performance counters. When it is undefined both
// outputs are tied to zero and no counter flops exist. Control behaviour is the
// same in both builds.
//
// The update codes and pc_en are Mealy outputs. They are produced
// combinationally from the state and the inputs, and the pipeline registers
// consume them on the same edge.

module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  d_rs,
    input  logic [5:0]  d_rt,
    input  logic        d_uses_s,
    input  logic        d_uses_t,
    input  logic [1:0]  de_rw,
    input  logic [4:0]  de_rd,
    input  logic [4:0]  de_wait_time,
    input  logic        de_stop,
    input  logic        e_redirect,
    input  logic        resume,
    output logic [1:0]  fd_update,
    output logic [1:0]  de_update,
    output logic [1:0]  ew_update,
    output logic        pc_en,
    output logic        halted,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    localparam int unsigned ECNT_W = 5;
    localparam int unsigned CNT_W  = 32;

    localparam logic [1:0] UPD_HOLD    = 2'b00;
    localparam logic [1:0] UPD_ADVANCE = 2'b01;
    localparam logic [1:0] UPD_FLUSH   = 2'b10;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ECNT_W-1:0]   ecnt_q, ecnt_d;

    logic [ECNT_W-1:0]   wait_eff;
    logic                done;
    logic                raw_s;
    logic                raw_t;
    logic                raw;
    logic                stop_done;
    logic                redirect_done;

    // E-stage completion: a wait time of 0 behaves like 1; compare in 6 bits
    // so that ecnt+1 cannot wrap.
    always_comb begin
        wait_eff = (de_wait_time == '0) ? ECNT_W'(1) : de_wait_time;
        done     = ((6'({1'b0, ecnt_q}) + 6'd1) >= 6'({1'b0, wait_eff}));
    end

    // D/E read-after-write detection; file select and index must both match,
    // and register 0 gets no exemption.
    always_comb begin
        raw_s = d_uses_s && (de_rw[1] == d_rs[5]) && (de_rd == d_rs[4:0]);
        raw_t = d_uses_t && (de_rw[1] == d_rt[5]) && (de_rd == d_rt[4:0]);
        raw   = (de_rw != 2'b00) && (raw_s || raw_t);
    end

    // Stop and redirect only take effect once the E instruction has completed.
    always_comb begin
        stop_done     = done && de_stop;
        redirect_done = done && e_redirect;
    end

    // State and E-cycle counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ecnt_q  <= ecnt_d;
        end
    end

    // Next-state and Mealy update/pc_en decode; reset forces a full flush.
    always_comb begin
        state_d   = state_q;
        ecnt_d    = ecnt_q;
        fd_update = UPD_HOLD;
        de_update = UPD_HOLD;
        ew_update = UPD_HOLD;
        pc_en     = 1'b0;

        if (rst) begin
            fd_update = UPD_FLUSH;
            de_update = UPD_FLUSH;
            ew_update = UPD_FLUSH;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (stop_done) begin
                        // Let the stop retire, squash younger slots, then halt.
                        fd_update = UPD_FLUSH;
                        de_update = UPD_FLUSH;
                        ew_update = UPD_ADVANCE;
                        ecnt_d    = '0;
                        state_d   = S_HALT;
                    end else if (redirect_done) begin
                        // Squash the two wrong-path slots and load the new PC.
                        fd_update = UPD_FLUSH;
                        de_update = UPD_FLUSH;
                        ew_update = UPD_ADVANCE;
                        pc_en     = 1'b1;
                        ecnt_d    = '0;
                    end else if (!done) begin
                        // Multi-cycle E: freeze the front, keep E/W bubbled.
                        ew_update = UPD_FLUSH;
                        ecnt_d    = ecnt_q + ECNT_W'(1);
                    end else if (raw) begin
                        // Hold D, send a bubble into E while the producer retires.
                        de_update = UPD_FLUSH;
                        ew_update = UPD_ADVANCE;
                        ecnt_d    = '0;
                    end else begin
                        fd_update = UPD_ADVANCE;
                        de_update = UPD_ADVANCE;
                        ew_update = UPD_ADVANCE;
                        pc_en     = 1'b1;
                        ecnt_d    = '0;
                    end
                end
                S_HALT: begin
                    if (resume) begin
                        state_d = S_RUN;
                        ecnt_d  = '0;
                    end
                end
                default: begin
                    state_d = S_RUN;
                    ecnt_d  = '0;
                end
            endcase
        end
    end

    // The halt flag is taken directly from the state register.
    always_comb begin
        halted = (state_q == S_HALT);
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic             stall_inc;
    logic             flush_inc;

    // Stall cycles are RUN cycles without a PC load, excluding the stop cycle.
    always_comb begin
        stall_inc = (state_q == S_RUN) && !pc_en && !stop_done;
        flush_inc = (state_q == S_RUN) && redirect_done && !stop_done;
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_inc && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush_inc && (flush_q != {CNT_W{1'b1}})) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl. Inputs change just
// after a rising edge. The Mealy outputs are checked before the next edge, and
// the registered counters are checked just after it.
`timescale 1ns/1ps

module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  d_rs, d_rt;
    logic        d_uses_s, d_uses_t;
    logic [1:0]  de_rw;
    logic [4:0]  de_rd;
    logic [4:0]  de_wait_time;
    logic        de_stop, e_redirect, resume;
    logic [1:0]  fd_update, de_update, ew_update;
    logic        pc_en, halted;
    logic [31:0] stall_cycles, flush_count;

    int errors = 0;
    int checks = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .d_rs         (d_rs),
        .d_rt         (d_rt),
        .d_uses_s     (d_uses_s),
        .d_uses_t     (d_uses_t),
        .de_rw        (de_rw),
        .de_rd        (de_rd),
        .de_wait_time (de_wait_time),
        .de_stop      (de_stop),
        .e_redirect   (e_redirect),
        .resume       (resume),
        .fd_update    (fd_update),
        .de_update    (de_update),
        .ew_update    (ew_update),
        .pc_en        (pc_en),
        .halted       (halted),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [1:0] fd, input logic [1:0] de,
                              input logic [1:0] ew, input logic pc, input logic h);
        chk({tag, ".fd"}, 32'(fd_update), 32'(fd));
        chk({tag, ".de"}, 32'(de_update), 32'(de));
        chk({tag, ".ew"}, 32'(ew_update), 32'(ew));
        chk({tag, ".pc_en"}, 32'(pc_en), 32'(pc));
        chk({tag, ".halted"}, 32'(halted), 32'(h));
    endtask

    task automatic expect_cnt(input string tag);
        chk({tag, ".stall_cycles"}, stall_cycles, 32'(exp_stall));
        chk({tag, ".flush_count"}, flush_count, 32'(exp_flush));
    endtask

    // One cycle: check the Mealy outputs, clock, then check the counters.
    task automatic step(input string tag, input logic [1:0] fd, input logic [1:0] de,
                        input logic [1:0] ew, input logic pc, input logic h,
                        input int si, input int fi);
        #1;
        expect_out(tag, fd, de, ew, pc, h);
        @(posedge clk);
        #1;
        if (PERF) begin
            exp_stall += si;
            exp_flush += fi;
        end
        expect_cnt(tag);
    endtask

    task automatic set_in(input logic [5:0] rs, input logic [5:0] rt, input logic us,
                          input logic ut, input logic [1:0] rw, input logic [4:0] rd,
                          input logic [4:0] wt, input logic stp, input logic rdr,
                          input logic res);
        d_rs = rs; d_rt = rt; d_uses_s = us; d_uses_t = ut;
        de_rw = rw; de_rd = rd; de_wait_time = wt;
        de_stop = stp; e_redirect = rdr; resume = res;
    endtask

    initial begin
        rst = 1'b1;
        set_in(6'd0, 6'd0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        expect_out("reset", 2'b10, 2'b10, 2'b10, 1'b0, 1'b0);
        expect_cnt("reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Independent instructions, including wait time 0 treated as 1.
        step("adv0", 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 0, 0);
        step("adv1", 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 0, 0);
        set_in(6'd0, 6'd0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step("wait0", 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 0, 0);

        // Multi-cycle E of wait time 4: three stalls then advance.
        set_in(6'd0, 6'd0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0);
        step("mc0", 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1, 0);
        step("mc1", 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1, 0);
        step("mc2", 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1, 0);
        step("mc3", 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 0, 0);

        // RAW hazards on int r5, via s and t, and the FP / no-use / no-write cases.
        set_in(6'h05, 6'd0, 1'b1, 1'b0, 2'b01, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0);
        step("raw_s", 2'b00, 2'b10, 2'b01, 1'b0, 1'b0, 1, 0);
        set_in(6'h25, 6'd0, 1'b1, 1'b0, 2'b01, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0);
        step("fp_vs_int", 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 0, 0);
        set_in(6'h05, 6'd0, 1'b0, 1'b0, 2'b01, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0);
        step("no_use", 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 0, 0);
        set_in(6'd0, 6'h05, 1'b0, 1'b1, 2'b01, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0);
        step("raw_t", 2'b00, 2'b10, 2'b01, 1'b0, 1'b0, 1, 0);
        set_in(6'h25, 6'd0, 1'b1, 1'b0, 2'b10, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0);
        step("raw_fp", 2'b00, 2'b10, 2'b01, 1'b0, 1'b0, 1, 0);
        set_in(6'h25, 6'd0, 1'b1, 1'b0, 2'b00, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0);
        step("no_write", 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 0, 0);
        set_in(6'h00, 6'd0, 1'b1, 1'b0, 2'b01, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0);
        step("raw_r0", 2'b00, 2'b10, 2'b01, 1'b0, 1'b0, 1, 0);

        // Multi-cycle stall has priority over RAW, then RAW resolves.
        set_in(6'h05, 6'd0, 1'b1, 1'b0, 2'b01, 5'd5, 5'd2, 1'b0, 1'b0, 1'b0);
        step("mc_raw0", 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1, 0);
        step("mc_raw1", 2'b00, 2'b10, 2'b01, 1'b0, 1'b0, 1, 0);

        // Redirect with wait time 3: ignored for two stall cycles, then flush.
        set_in(6'd0, 6'd0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd3, 1'b0, 1'b1, 1'b0);
        step("redir0", 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1, 0);
        step("redir1", 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1, 0);
        step("redir2", 2'b10, 2'b10, 2'b01, 1'b1, 1'b0, 0, 1);

        // Stop (with redirect also set; stop wins), halt, resume.
        set_in(6'd0, 6'd0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0);
        step("stop", 2'b10, 2'b10, 2'b01, 1'b0, 1'b0, 0, 0);
        set_in(6'h05, 6'd0, 1'b1, 1'b0, 2'b01, 5'd5, 5'd3, 1'b1, 1'b1, 1'b0);
        step("halt0", 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 0, 0);
        step("halt1", 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 0, 0);
        set_in(6'd0, 6'd0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd1, 1'b0, 1'b0, 1'b1);
        step("halt_res", 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 0, 0);
        set_in(6'd0, 6'd0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0);
        step("run_again", 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 0, 0);

        // Reset mid-stall at ecnt=2 acts without a clock edge and clears progress.
        set_in(6'd0, 6'd0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
        step("ms0", 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1, 0);
        step("ms1", 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        expect_out("mid_rst", 2'b10, 2'b10, 2'b10, 1'b0, 1'b0);
        expect_cnt("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        set_in(6'd0, 6'd0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0);
        step("post_rst0", 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1, 0);
        step("post_rst1", 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1, 0);
        step("post_rst2", 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit that drives the 2-bit `update` inputs of the F/D, D/E and E/W pipeline registers and the PC enable. Encoding: 2'b01 advance, 2'b10 flush (insert bubble), 2'b00 hold. The block resolves:
- multi-cycle execute stalls, from the E-stage wait time;
- read-after-write stalls between the D and E stages;
- control-flow redirect flushes;
- the stop/halt sequence.

It sits beside the pipeline registers and is the sole producer of their `update` signals.

## Interface
- No parameters.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `d_rs` input 6: D-stage source s; bit 5 selects the FP file, [4:0] the register index.
- `d_rt` input 6: D-stage source t; same encoding as `d_rs`.
- `d_uses_s`, `d_uses_t` input 1 each: D instruction actually reads s / t.
- `de_rw` input 2: E instruction write enable; 00 none, bit 1 selects the FP file.
- `de_rd` input 5: E instruction destination index.
- `de_wait_time` input 5: E-stage cycles required by the E instruction; 0 is treated as 1.
- `de_stop` input 1: E instruction is a stop.
- `e_redirect` input 1: E instruction changes control flow (taken branch, jump, jr).
- `resume` input 1: leave the halt state.
- `fd_update`, `de_update`, `ew_update` output 2 each: update codes to the pipeline registers.
- `pc_en` output 1: PC register loads its next value.
- `halted` output 1: the controller is in the HALT state.
- `stall_cycles` output 32: cycles with `pc_en`=0 in RUN; see Configuration.
- `flush_count` output 32: redirect flushes; see Configuration.

## Operation
- States: RUN, HALT.
- Register `ecnt` [4:0] counts cycles the current E instruction has spent in E.
- `done` = ({1'b0,ecnt}+1 >= max(de_wait_time,1)), evaluated in 6 bits.
- `raw` is asserted when `de_rw`!=0 and either:
  - `d_uses_s`, `de_rw[1]`==`d_rs[5]` and `de_rd`==`d_rs[4:0]`; or
  - the same test on `d_rt` with `d_uses_t`.
  - There is no register-0 exemption.
- RUN decisions, first match wins:
  1. `done` & `de_stop`: fd=10, de=10, ew=01, pc_en=0; next state HALT.
  2. `done` & `e_redirect`: fd=10, de=10, ew=01, pc_en=1.
  3. !`done`: fd=00, de=00, ew=10, pc_en=0.
  4. `raw`: fd=00, de=10, ew=01, pc_en=0.
  5. otherwise: fd=01, de=01, ew=01, pc_en=1.
- `e_redirect` and `de_stop` are ignored until `done`.
- `ecnt` update:
  - cleared whenever ew=01 is issued;
  - incremented when ew=10 is issued because of !`done`;
  - never wraps, since `done` asserts no later than `ecnt`=30.
- HALT:
  - outputs fd=00, de=00, ew=00, pc_en=0, `halted`=1;
  - `resume` moves the controller to RUN on the next edge with `ecnt`=0;
  - no other input has effect.
- A bubble in E carries wait_time 1, so it completes in one cycle.

## Timing
- All `update` outputs and `pc_en` are combinational from state and inputs (Mealy). They are consumed by the registers on the same edge.
- Latency:
  - RAW stall: 1 cycle per blocking E instruction.
  - Multi-cycle E of wait time N: N-1 stall cycles, then advance.
  - Redirect: 2 squashed slots (F/D and D/E).
- Reset behaviour:
  - While `rst`=1, the outputs are fd=de=ew=10, pc_en=0 and `halted`=0.
  - State becomes RUN; `ecnt`, `stall_cycles` and `flush_count` become 0.
  - Reset mid-stall or mid-halt discards all progress.
- `halted` rises the cycle after the stop completes and falls the cycle after `resume` is sampled.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `stall_cycles` increments on every RUN cycle with `pc_en`=0, excluding rule 1.
  - `flush_count` increments on every rule-2 cycle.
  - Both counters saturate at 32'hffffffff.
- Undefined: both outputs are constant 0 and no counter flops are built.
- Control behaviour is identical either way.

## Test plan
- Independent instructions, wait_time 1, no hazards -> fd/de/ew all 01 and pc_en=1 every cycle; `ecnt` stays 0.
- E wait_time 4 -> three cycles of fd=00, de=00, ew=10, pc_en=0, then all 01; with PERF_EN, `stall_cycles`=3.
- E writes int r5 (de_rw=01, de_rd=5); D reads r5 via s -> one cycle of fd=00, de=10, ew=01. FP r5 (d_rs=6'h25) against the same E instruction -> no stall.
- e_redirect with wait_time 3 -> stall for 2 cycles, then fd=10, de=10, ew=01, pc_en=1 once; with PERF_EN, `flush_count`=1.
- de_stop completes -> ew=01, fd=de=10; `halted`=1 next cycle with all updates 00; resume -> RUN next cycle.
- `rst` asserted mid-stall (ecnt=2) -> outputs become 10/10/10 immediately without a clock edge; after release, `ecnt`=0 and state is RUN.
